// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and synchroniser depth for the dual-clock FIFO pointer logic.
package gray_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int GRAY_MAX_W  = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Callers zero-extend into gray_word_t and truncate the result back to their width.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_sync
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Plain flop chain: nothing may sit between stages on a crossing path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_wptr_gen.sv
// Write-side FIFO pointer: binary write pointer, registered Gray pointer out, synchronised full flag.
// Optional macro GRAY_WPTR_LEVEL_EN adds a pessimistic fill_level output.
module gray_wptr_gen
    import gray_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int PTR_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    output logic                  push_ready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH-1:0]  wptr_gray,
    input  logic [PTR_WIDTH-1:0]  rptr_gray,
    output logic                  full
`ifdef GRAY_WPTR_LEVEL_EN
    ,
    output logic [PTR_WIDTH-1:0]  fill_level
`endif
);

    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] wbin_next;
    logic [PTR_WIDTH-1:0] wgray_next;
    logic [PTR_WIDTH-1:0] rq2;
    logic [PTR_WIDTH-1:0] full_match;
    logic                 accept;

    gray_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rptr_gray),
        .q     (rq2)
    );

    assign accept     = push_valid & ~full;
    assign wbin_next  = wbin + PTR_WIDTH'(accept);
    assign wgray_next = PTR_WIDTH'(bin2gray(gray_word_t'(wbin_next)));

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign full_match = {~rq2[PTR_WIDTH-1:PTR_WIDTH-2], rq2[PTR_WIDTH-3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            full      <= (wgray_next == full_match);
        end
    end

    assign push_ready = ~full;
    assign waddr      = wbin[ADDR_WIDTH-1:0];

`ifdef GRAY_WPTR_LEVEL_EN
    // Read pointer is stale by the sync latency, so this over-reports occupancy.
    assign fill_level = wbin - PTR_WIDTH'(gray2bin(gray_word_t'(rq2)));
`endif

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Directed and randomised checks of gray_wptr_gen at ADDR_WIDTH=2 (3-bit pointers).
`timescale 1ns/1ps
module tb_gray_wptr_gen;

    localparam int AW = 2;
    localparam int PW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] rptr_gray = '0;
    logic          full;
`ifdef GRAY_WPTR_LEVEL_EN
    logic [PW-1:0] fill_level;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    gray_wptr_gen #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .waddr      (waddr),
        .wptr_gray  (wptr_gray),
        .rptr_gray  (rptr_gray),
        .full       (full)
`ifdef GRAY_WPTR_LEVEL_EN
        ,
        .fill_level (fill_level)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] g(input int b);
        logic [PW-1:0] v;
        v = PW'(b & 7);
        return v ^ (v >> 1);
    endfunction

    function automatic int g2b(input logic [PW-1:0] gv);
        logic [PW-1:0] b;
        b[2] = gv[2];
        b[1] = b[2] ^ gv[1];
        b[0] = b[1] ^ gv[0];
        return int'(b);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        push_valid = 1'b0;
        rptr_gray  = '0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (wptr_gray !== 3'b000) $display("FAIL reset_wptr got %b exp 000", wptr_gray);
        else pass_cnt++;
        total_cnt++;
        if (full !== 1'b0 || push_ready !== 1'b1) $display("FAIL reset_full got full=%b ready=%b exp 0/1", full, push_ready);
        else pass_cnt++;
        total_cnt++;
        if (waddr !== 2'd0) $display("FAIL reset_waddr got %0d exp 0", waddr);
        else pass_cnt++;
`ifdef GRAY_WPTR_LEVEL_EN
        total_cnt++;
        if (fill_level !== 3'd0) $display("FAIL reset_level got %0d exp 0", fill_level);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [PW-1:0] exp_g [5];
        exp_g[0] = 3'b001; exp_g[1] = 3'b011; exp_g[2] = 3'b010;
        exp_g[3] = 3'b110; exp_g[4] = 3'b110;
        rptr_gray  = '0;
        push_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total_cnt++;
            if (wptr_gray !== exp_g[k]) $display("FAIL fill_wptr[%0d] got %b exp %b", k, wptr_gray, exp_g[k]);
            else pass_cnt++;
            total_cnt++;
            if (full !== (k >= 3) || push_ready !== (k < 3))
                $display("FAIL fill_full[%0d] got full=%b ready=%b exp full=%0d", k, full, push_ready, k >= 3);
            else pass_cnt++;
            total_cnt++;
            if (int'(waddr) !== ((k >= 3) ? 0 : k + 1)) $display("FAIL fill_waddr[%0d] got %0d", k, waddr);
            else pass_cnt++;
        end
        push_valid = 1'b0;
    endtask

    task automatic test_drain_release();
        rptr_gray = 3'b001;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            total_cnt++;
            if (full !== (e < 3)) $display("FAIL release_full edge %0d got %b exp %0d", e, full, e < 3);
            else pass_cnt++;
        end
        push_valid = 1'b1;
        @(negedge clk);
        push_valid = 1'b0;
        total_cnt++;
        if (wptr_gray !== 3'b111) $display("FAIL release_push_wptr got %b exp 111", wptr_gray);
        else pass_cnt++;
        total_cnt++;
        if (full !== 1'b1 || waddr !== 2'd1) $display("FAIL release_push_full got full=%b waddr=%0d exp 1/1", full, waddr);
        else pass_cnt++;
    endtask

    task automatic test_reset_midcycle();
        push_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (wptr_gray !== 3'b000 || waddr !== 2'd0) $display("FAIL midreset_ptr got wptr=%b waddr=%0d exp 000/0", wptr_gray, waddr);
        else pass_cnt++;
        total_cnt++;
        if (full !== 1'b0 || push_ready !== 1'b1) $display("FAIL midreset_full got full=%b ready=%b exp 0/1", full, push_ready);
        else pass_cnt++;
        push_valid = 1'b0;
        rptr_gray  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            push_valid = 1'b1;
            @(negedge clk);
            push_valid = 1'b0;
            total_cnt++;
            if (wptr_gray !== g(k) || int'(waddr) !== (k % 4))
                $display("FAIL wrap_ptr[%0d] got wptr=%b waddr=%0d exp %b/%0d", k, wptr_gray, waddr, g(k), k % 4);
            else pass_cnt++;
            total_cnt++;
            if (full !== 1'b0) $display("FAIL wrap_full[%0d] got %b exp 0", k, full);
            else pass_cnt++;
            rptr_gray = (k >= 2) ? g(k - 2) : 3'b000;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_gray_invariant();
        int            wbin_m, rbin_m, wn, fails_shown;
        logic [PW-1:0] rq1_m, rq2_m, prev;
        logic          full_m, acc;
        do_reset();
        wbin_m = 0; rbin_m = 0; rq1_m = '0; rq2_m = '0; full_m = 1'b0; fails_shown = 0;
        for (int c = 0; c < 10000; c++) begin
            prev       = wptr_gray;
            push_valid = ($urandom_range(0, 2) != 0);
            if (rbin_m != wbin_m && $urandom_range(0, 2) == 0) rbin_m = (rbin_m + 1) & 7;
            rptr_gray = g(rbin_m);
            acc    = push_valid && !full_m;
            wn     = (wbin_m + int'(acc)) & 7;
            full_m = (((wn - g2b(rq2_m)) & 7) == 4);
            rq2_m  = rq1_m;
            rq1_m  = rptr_gray;
            wbin_m = wn;
            @(negedge clk);
            total_cnt++;
            if ($countones(prev ^ wptr_gray) > 1 || wptr_gray !== g(wbin_m) || full !== full_m) begin
                if (fails_shown < 10)
                    $display("FAIL random[%0d] got wptr=%b full=%b prev=%b exp wptr=%b full=%b",
                             c, wptr_gray, full, prev, g(wbin_m), full_m);
                fails_shown++;
            end else pass_cnt++;
        end
        push_valid = 1'b0;
    endtask

`ifdef GRAY_WPTR_LEVEL_EN
    task automatic test_level();
        do_reset();
        push_valid = 1'b1;
        repeat (3) @(negedge clk);
        push_valid = 1'b0;
        total_cnt++;
        if (fill_level !== 3'd3) $display("FAIL level_3 got %0d exp 3", fill_level);
        else pass_cnt++;
        rptr_gray = 3'b011;
        @(negedge clk);
        total_cnt++;
        if (fill_level !== 3'd3) $display("FAIL level_1edge got %0d exp 3", fill_level);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (fill_level !== 3'd1) $display("FAIL level_2edge got %0d exp 1", fill_level);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain_release();
        test_reset_midcycle();
        test_wrap();
        test_gray_invariant();
`ifdef GRAY_WPTR_LEVEL_EN
        test_level();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gray_wptr_gen.md
Name: gray_wptr_gen

Overview:
- Write-side pointer generator for a dual-clock FIFO. It is the binary-to-Gray counterpart of the existing Gray-to-binary decoder.
- Keeps a binary write pointer and publishes it as a registered Gray-coded pointer for the read domain.
- Synchronises the read domain's Gray pointer into the write clock and produces a registered full flag with a push handshake.
- Sits in the write clock domain, next to the FIFO storage array.

Parameters:
ADDR_WIDTH, 3, storage address width; FIFO depth = 2**ADDR_WIDTH; legal range >= 2
PTR_WIDTH, ADDR_WIDTH+1, pointer width including the wrap bit (derived; do not override)

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
push_valid  input  1  producer requests a write
push_ready  output  1  block can accept a write (= !full)
waddr  output  ADDR_WIDTH  storage write address for the current accept
wptr_gray  output  PTR_WIDTH  registered Gray write pointer, to the read domain
rptr_gray  input  PTR_WIDTH  Gray read pointer from the read domain (asynchronous)
full  output  1  registered FIFO-full flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: wbin=0, wptr_gray=0, both sync stages=0, full=0. So push_ready=1 and waddr=0. Reset takes effect immediately, mid-transfer included; no partial state survives.
- Accept: accept = push_valid & !full. Data for waddr is written by the storage on the same edge.
- Pointer update on each clk edge:
  - wbin_next = wbin + accept, modulo 2**PTR_WIDTH.
  - wptr_gray <= wbin_next ^ (wbin_next >> 1).
  - wptr_gray updates in the cycle after the accept.
  - wptr_gray is driven straight from a flop; no combinational logic on the crossing path.
- waddr = wbin[ADDR_WIDTH-1:0], a combinational tap of the register.
- Synchroniser: rptr_gray passes through 2 flops (rq1, rq2) with no logic between them.
- Full:
  - full <= (gray(wbin_next) == {~rq2[PTR_WIDTH-1:PTR_WIDTH-2], rq2[PTR_WIDTH-3:0]}).
  - Full asserts in the cycle after the accept that fills the FIFO.
  - Full deasserts no earlier than 3 clk edges after the read domain advances rptr_gray: 2 sync edges plus 1 register edge. This pessimism is intended.
- Push while full: ignored; wbin, wptr_gray and waddr are unchanged. No error output.
- Wrap-around:
  - wbin rolls from all-ones to 0.
  - The Gray value goes from 100..0 to 000..0, a single-bit change.
  - waddr wraps at the depth boundary while the wrap bit toggles.
- Simultaneous accept and rq2 change: full is computed from post-accept wbin_next and the current rq2. No priority issues arise because the read side never decreases the pointer.
- Successive wptr_gray values must differ by exactly one bit (Gray invariant).

Optional Feature:
- Macro: GRAY_WPTR_LEVEL_EN.
- When defined:
  - Adds output fill_level [PTR_WIDTH-1:0] = wbin - g2b(rq2), modulo 2**PTR_WIDTH, combinational from registers.
  - Reset value is 0. The value is pessimistic (over-reports) by the sync latency.
  - The Gray-to-binary conversion must cover every bit, including bit 0.
- When undefined: the port and the conversion logic are absent.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(b) = b ^ (b >> 1).
  - function gray2bin(g): prefix XOR from MSB down to bit 0 inclusive.
  - localparam SYNC_STAGES = 2.
- One sub-module, gray_sync: a PTR_WIDTH-wide, SYNC_STAGES-deep flop chain with async active-low reset. It is reused for the read side later.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 and push_ready=1 immediately, without waiting for a clk edge.
2. ADDR_WIDTH=2, rptr_gray=0, push_valid held for 4 cycles:
   - wptr_gray sequence 001, 011, 010, 110.
   - full=1 in the cycle after the 4th accept.
   - 5th push ignored; wptr_gray stays 110.
3. From scenario 2, drive rptr_gray=001 -> full falls exactly 3 edges later; the next push gives wptr_gray=111.
4. Wrap: 8 pushes with rptr_gray tracking 2 behind -> wbin 111->000, wptr_gray 100->000, waddr 3->0, full never asserts.
5. Gray invariant: random push_valid and random legal rptr advances for 10k cycles -> Hamming distance between consecutive wptr_gray values is <= 1, and full matches a reference occupancy model delayed by sync latency.
6. GRAY_WPTR_LEVEL_EN defined, 3 pushes with rptr_gray=0 -> fill_level=3; then rptr_gray=011 (binary 2) -> fill_level=1 after 2 edges.
